mem_responder_mmio: RTL and testbench
=====================================

# mem_responder_mmio

Memory-side responder for the CPU's single 16-bit memory port: it answers the read and write requests the CPU memory controller issues. Word-addressed RAM with one-cycle read latency, plus a 16-word memory-mapped I/O window. The window provides a cycle counter, a scratch register, a write counter and a done/pass mailbox, so stimulus programs can report their own result. It sits in the top-level benches in place of the plain memory model; RAM contents are preloaded through the hierarchical array `ram`.

## Interface
- MEM_DEPTH, 4096: RAM words; must be 2**ADDR_WIDTH.
- ADDR_WIDTH, $clog2(MEM_DEPTH) = 12: word-address width.
- PASS_SIG, 16'h600D: value written to DONE that signals pass.
- clock  in  1  single clock, rising-edge.
- reset  in  1  synchronous, active-low.
- MEMCTRL_MEM_to_mem_mem_enable  in  1  request qualifier.
- MEMCTRL_MEM_to_mem_read_enable  in  1  read request.
- MEMCTRL_MEM_to_mem_write_enable  in  1  write request.
- MEMCTRL_MEM_to_mem_address  in  ADDR_WIDTH  word address.
- MEMCTRL_MEM_to_mem_data  in  16  write data.
- MEM_MEMCTRL_from_mem_data  out  16  read data.
- done  out  1  sticky; set by the first write to DONE.
- pass  out  1  sticky; captured with done.
- error  out  1  sticky OR of the protocol error and the ro-write error.

## Operation
- Request sampled at the rising edge when `reset`=1 and mem_enable=1.
- Read when rd=1 and wr=0. Write when wr=1 and rd=0.
- rd=wr=1 is illegal: no access is performed, protocol_error is set, and read data holds.
- mem_enable=0 or rd=wr=0: idle.
- Address decode:
  - 0x000–0xFEF: RAM.
  - 0xFF0–0xFFF: MMIO. RAM words in this range are unreachable.
- MMIO map:
  - 0xFF0 CYCLE_LO (ro): returns cyc[15:0] and latches cyc[31:16] into hi_latch.
  - 0xFF1 CYCLE_HI (ro): returns hi_latch.
  - 0xFF2 SCRATCH (rw): reset value 0.
  - 0xFF3 STATUS (ro): {12'b0, protocol_error, ro_write_error, pass, done}.
  - 0xFF4 DONE (wo, reads 0): a write sets done=1 and pass=(data==PASS_SIG). Only the first write counts; later writes are ignored and do not set any error.
  - 0xFF5 WR_COUNT (ro): count of accepted RAM writes, saturating at 16'hFFFF.
  - 0xFF6–0xFFF: reserved, read 0.
- A write to any ro or reserved address sets ro_write_error; no state changes.
- Cycle counter `cyc`:
  - 32-bit, increments every cycle while `reset`=1.
  - Wraps from 2^32−1 to 0.
  - A read returns the value `cyc` held before the sampling edge.
- RAM is not cleared by reset; the backdoor preload must survive reset.

## Timing
- All outputs and all registers go to 0 on reset: data out, done, pass, error, cyc, hi_latch, SCRATCH, WR_COUNT, both error flags.
- Read latency is 1. A read sampled at edge N gives data valid after edge N+1's setup.
  - Data out holds until the next legal read completes; writes and idle cycles do not change it.
- A write sampled at edge N is visible to a read sampled at edge N+1. There is no forwarding hazard because the RAM writes at edge N.
- Back-to-back reads are supported, one per cycle.
- Read → write → read to the same address returns the written value.
- done, pass and error change one cycle after the sampling edge and then hold until reset.
- Reset asserted mid-read: the pending read is discarded and data out is 0 on the cycle after reset is sampled.
- CYCLE_HI read without a prior CYCLE_LO read returns hi_latch (0 after reset).

## Structure
- Package `mem_responder_pkg` holds:
  - MMIO base 12'hFF0 and register offset constants;
  - STATUS bit indices;
  - default PASS_SIG;
  - a request-kind enum {IDLE, READ, WRITE, ILLEGAL}.
- One sub-module, `mem_responder_ram`: single-port synchronous array `ram[MEM_DEPTH]` of 16 bits with registered read.
  - The top instance is named so that the existing preload path `memory_i.ram` becomes `memory_i.u_ram.ram`. Benches update the path.
- MMIO decode, registers and the output mux live in the top module.

## Test plan
- Preload ram[0x010]=16'hBEEF. Read 0x010 at edge N → data out 16'hBEEF after edge N+1. It holds through two idle cycles.
- Write 0x020←16'h1234, then read 0x020 on the next cycle → 16'h1234. WR_COUNT read → 1.
- Run 70000 cycles, then read 0xFF0 then 0xFF1 → together they give the 32-bit count at the CYCLE_LO edge (high half 16'h0001). Force cyc to 32'hFFFF_FFFF → next value 0.
- Write DONE←16'h600D → done=1 and pass=1 one cycle later. A second write of 16'h0BAD leaves pass=1. STATUS read → 16'h0003.
- Assert rd=wr=1 at 0x030, then write 0xFF3 → error=1, ram[0x030] unchanged, STATUS read → 16'h000C.
- Reset low during a read of 0x010 → data out 0 the next cycle, done=pass=error=0, and ram[0x010] still 16'hBEEF afterwards.

Source files
------------

// File: rtl/mem_responder_pkg.sv
// ============================================================================
// Module      : mem_responder_pkg
// Description : Shared constants and request classification for the memory
//               responder (MMIO map, STATUS bit positions, pass signature).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_responder_pkg;

    localparam logic [11:0] c_MMIO_BASE        = 12'hFF0;
    localparam int          c_MMIO_OFF_BITS    = 4;

    localparam logic [3:0]  c_OFF_CYCLE_LO     = 4'h0;
    localparam logic [3:0]  c_OFF_CYCLE_HI     = 4'h1;
    localparam logic [3:0]  c_OFF_SCRATCH      = 4'h2;
    localparam logic [3:0]  c_OFF_STATUS       = 4'h3;
    localparam logic [3:0]  c_OFF_DONE         = 4'h4;
    localparam logic [3:0]  c_OFF_WR_COUNT     = 4'h5;

    localparam int          c_STAT_DONE        = 0;
    localparam int          c_STAT_PASS        = 1;
    localparam int          c_STAT_RO_ERR      = 2;
    localparam int          c_STAT_PROTO_ERR   = 3;

    localparam logic [15:0] c_DEFAULT_PASS_SIG = 16'h600D;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        READ    = 2'd1,
        WRITE   = 2'd2,
        ILLEGAL = 2'd3
    } req_kind_e;

    function automatic req_kind_e f_classify(input logic en, input logic rd, input logic wr);
        req_kind_e kind;
        kind = IDLE;
        if (en) begin
            if (rd && wr) begin
                kind = ILLEGAL;
            end else if (rd) begin
                kind = READ;
            end else if (wr) begin
                kind = WRITE;
            end
        end
        return kind;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_responder_ram.sv
// ============================================================================
// Module      : mem_responder_ram
// Description : Single-port synchronous word RAM with registered read data.
//               The array is never reset so backdoor preloads survive reset.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_responder_ram #(
    parameter int DEPTH = 4096,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          we_i,
    input  logic          re_i,
    input  logic [AW-1:0] addr_i,
    input  logic [15:0]   wdata_i,
    output logic [15:0]   rdata_o
);

    logic [15:0] ram [DEPTH];
    logic [15:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            ram[addr_i] <= wdata_i;
        end
    end

    // Read register only moves on a real read, so data holds across idles.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rdata_q <= 16'h0000;
        end else if (re_i) begin
            rdata_q <= ram[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

`default_nettype wire

// File: rtl/mem_responder_mmio.sv
// ============================================================================
// Module      : mem_responder_mmio
// Description : CPU memory-port responder: word RAM plus a 16-word MMIO window
//               (cycle counter, scratch, write counter, done/pass mailbox).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_responder_mmio
    import mem_responder_pkg::*;
#(
    parameter int          MEM_DEPTH  = 4096,
    parameter int          ADDR_WIDTH = $clog2(MEM_DEPTH),
    parameter logic [15:0] PASS_SIG   = c_DEFAULT_PASS_SIG
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  MEMCTRL_MEM_to_mem_mem_enable,
    input  logic                  MEMCTRL_MEM_to_mem_read_enable,
    input  logic                  MEMCTRL_MEM_to_mem_write_enable,
    input  logic [ADDR_WIDTH-1:0] MEMCTRL_MEM_to_mem_address,
    input  logic [15:0]           MEMCTRL_MEM_to_mem_data,
    output logic [15:0]           MEM_MEMCTRL_from_mem_data,
    output logic                  done,
    output logic                  pass,
    output logic                  error
);

    // Window sits in the top 16 words; for 12-bit addresses this is 0xFF0.
    localparam logic [ADDR_WIDTH-1:0] c_WIN_BASE =
        {ADDR_WIDTH{1'b1}} ^ ADDR_WIDTH'(~c_MMIO_BASE);

    req_kind_e   w_kind;
    logic        w_is_mmio;
    logic [3:0]  w_off;
    logic        w_ram_we;
    logic        w_ram_re;
    logic [15:0] w_ram_rdata;
    logic [15:0] w_status;

    logic [31:0] cyc_q,         cyc_d;
    logic [15:0] hi_latch_q,    hi_latch_d;
    logic [15:0] scratch_q,     scratch_d;
    logic [15:0] wr_cnt_q,      wr_cnt_d;
    logic [15:0] mmio_rdata_q,  mmio_rdata_d;
    logic        sel_mmio_q,    sel_mmio_d;
    logic        done_q,        done_d;
    logic        pass_q,        pass_d;
    logic        ro_err_q,      ro_err_d;
    logic        proto_err_q,   proto_err_d;

    always_comb begin
        w_kind    = f_classify(reset & MEMCTRL_MEM_to_mem_mem_enable,
                               MEMCTRL_MEM_to_mem_read_enable,
                               MEMCTRL_MEM_to_mem_write_enable);
        w_is_mmio = (MEMCTRL_MEM_to_mem_address[ADDR_WIDTH-1:c_MMIO_OFF_BITS]
                     == c_WIN_BASE[ADDR_WIDTH-1:c_MMIO_OFF_BITS]);
        w_off     = MEMCTRL_MEM_to_mem_address[c_MMIO_OFF_BITS-1:0];
        w_ram_we  = (w_kind == WRITE) && !w_is_mmio;
        w_ram_re  = (w_kind == READ)  && !w_is_mmio;
    end

    always_comb begin
        w_status                   = 16'h0000;
        w_status[c_STAT_DONE]      = done_q;
        w_status[c_STAT_PASS]      = pass_q;
        w_status[c_STAT_RO_ERR]    = ro_err_q;
        w_status[c_STAT_PROTO_ERR] = proto_err_q;
    end

    always_comb begin
        cyc_d        = cyc_q + 32'd1;
        hi_latch_d   = hi_latch_q;
        scratch_d    = scratch_q;
        wr_cnt_d     = wr_cnt_q;
        mmio_rdata_d = mmio_rdata_q;
        sel_mmio_d   = sel_mmio_q;
        done_d       = done_q;
        pass_d       = pass_q;
        ro_err_d     = ro_err_q;
        proto_err_d  = proto_err_q;

        unique case (w_kind)
            READ: begin
                sel_mmio_d = w_is_mmio;
                if (w_is_mmio) begin
                    unique case (w_off)
                        c_OFF_CYCLE_LO: begin
                            mmio_rdata_d = cyc_q[15:0];
                            hi_latch_d   = cyc_q[31:16];
                        end
                        c_OFF_CYCLE_HI: mmio_rdata_d = hi_latch_q;
                        c_OFF_SCRATCH:  mmio_rdata_d = scratch_q;
                        c_OFF_STATUS:   mmio_rdata_d = w_status;
                        c_OFF_WR_COUNT: mmio_rdata_d = wr_cnt_q;
                        default:        mmio_rdata_d = 16'h0000;
                    endcase
                end
            end
            WRITE: begin
                if (w_is_mmio) begin
                    unique case (w_off)
                        c_OFF_SCRATCH: scratch_d = MEMCTRL_MEM_to_mem_data;
                        c_OFF_DONE: begin
                            // Mailbox latches only once; repeat writes are silently dropped.
                            if (!done_q) begin
                                done_d = 1'b1;
                                pass_d = (MEMCTRL_MEM_to_mem_data == PASS_SIG);
                            end
                        end
                        default: ro_err_d = 1'b1;
                    endcase
                end else if (wr_cnt_q != 16'hFFFF) begin
                    wr_cnt_d = wr_cnt_q + 16'd1;
                end
            end
            ILLEGAL: proto_err_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            cyc_q        <= 32'd0;
            hi_latch_q   <= 16'h0000;
            scratch_q    <= 16'h0000;
            wr_cnt_q     <= 16'h0000;
            mmio_rdata_q <= 16'h0000;
            sel_mmio_q   <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            ro_err_q     <= 1'b0;
            proto_err_q  <= 1'b0;
        end else begin
            cyc_q        <= cyc_d;
            hi_latch_q   <= hi_latch_d;
            scratch_q    <= scratch_d;
            wr_cnt_q     <= wr_cnt_d;
            mmio_rdata_q <= mmio_rdata_d;
            sel_mmio_q   <= sel_mmio_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
            ro_err_q     <= ro_err_d;
            proto_err_q  <= proto_err_d;
        end
    end

    mem_responder_ram #(
        .DEPTH (MEM_DEPTH),
        .AW    (ADDR_WIDTH)
    ) u_ram (
        .clk_i   (clock),
        .rst_ni  (reset),
        .we_i    (w_ram_we),
        .re_i    (w_ram_re),
        .addr_i  (MEMCTRL_MEM_to_mem_address),
        .wdata_i (MEMCTRL_MEM_to_mem_data),
        .rdata_o (w_ram_rdata)
    );

    assign MEM_MEMCTRL_from_mem_data = sel_mmio_q ? mmio_rdata_q : w_ram_rdata;
    assign done  = done_q;
    assign pass  = pass_q;
    assign error = proto_err_q | ro_err_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_responder_mmio.sv
// ============================================================================
// Module      : tb_mem_responder_mmio
// Description : Directed self-checking bench for mem_responder_mmio.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_responder_mmio;

    logic        clock  = 1'b0;
    logic        reset  = 1'b0;
    logic        en     = 1'b0;
    logic        rd     = 1'b0;
    logic        wr     = 1'b0;
    logic [11:0] addr   = 12'h000;
    logic [15:0] wdata  = 16'h0000;
    logic [15:0] rdata;
    logic        done;
    logic        pass;
    logic        error;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [15:0] exp_q[$];
    logic [31:0] m_cyc = 32'd0;
    logic [15:0] hi_exp;

    mem_responder_mmio dut (
        .clock                           (clock),
        .reset                           (reset),
        .MEMCTRL_MEM_to_mem_mem_enable   (en),
        .MEMCTRL_MEM_to_mem_read_enable  (rd),
        .MEMCTRL_MEM_to_mem_write_enable (wr),
        .MEMCTRL_MEM_to_mem_address      (addr),
        .MEMCTRL_MEM_to_mem_data         (wdata),
        .MEM_MEMCTRL_from_mem_data       (rdata),
        .done                            (done),
        .pass                            (pass),
        .error                           (error)
    );

    always #5 clock = ~clock;

    // Reference cycle count: cleared while reset is low, +1 per edge otherwise.
    always @(posedge clock) begin
        if (!reset) m_cyc <= 32'd0;
        else        m_cyc <= m_cyc + 32'd1;
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic pop_check(input string tag);
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $error("FAIL %s: observed %h expected <none queued>", tag, rdata);
        end else begin
            check(tag, rdata, exp_q.pop_front());
        end
    endtask

    task automatic drive(input logic e, input logic r, input logic w,
                         input logic [11:0] a, input logic [15:0] d);
        @(negedge clock);
        en = e; rd = r; wr = w; addr = a; wdata = d;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, 1'b0, 12'h000, 16'h0000);
    endtask

    task automatic do_write(input logic [11:0] a, input logic [15:0] d);
        drive(1'b1, 1'b0, 1'b1, a, d);
    endtask

    task automatic do_read(input logic [11:0] a, input logic [15:0] exp, input string tag);
        drive(1'b1, 1'b1, 1'b0, a, 16'h0000);
        exp_q.push_back(exp);
        idle(1);
        pop_check(tag);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: observed no finish expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        dut.u_ram.ram[12'h010] = 16'hBEEF;
        dut.u_ram.ram[12'h030] = 16'h5555;
        repeat (3) @(negedge clock);
        check("rst_data",  rdata,       16'h0000);
        check("rst_done",  16'(done),   16'h0000);
        check("rst_pass",  16'(pass),   16'h0000);
        check("rst_error", 16'(error),  16'h0000);
        @(negedge clock);
        reset = 1'b1;

        // RAM read latency and hold
        do_read(12'h010, 16'hBEEF, "ram_read");
        idle(1);
        check("hold1", rdata, 16'hBEEF);
        idle(1);
        check("hold2", rdata, 16'hBEEF);

        // Write then immediate read, write counter
        do_write(12'h020, 16'h1234);
        do_read(12'h020, 16'h1234, "wr_then_rd");
        do_read(12'hFF5, 16'h0001, "wr_count");

        // Back-to-back reads
        drive(1'b1, 1'b1, 1'b0, 12'h010, 16'h0000);
        exp_q.push_back(16'hBEEF);
        drive(1'b1, 1'b1, 1'b0, 12'h020, 16'h0000);
        pop_check("b2b_a");
        exp_q.push_back(16'h1234);
        idle(1);
        pop_check("b2b_b");

        // Scratch, write-only and reserved registers
        do_write(12'hFF2, 16'hA5A5);
        do_read(12'hFF2, 16'hA5A5, "scratch");
        do_read(12'hFF4, 16'h0000, "done_reads0");
        do_read(12'hFF9, 16'h0000, "reserved");
        do_read(12'hFF5, 16'h0001, "wr_count_ram_only");
        check("no_error", 16'(error), 16'h0000);

        // Long run, then split cycle-counter read
        idle(70000);
        drive(1'b1, 1'b1, 1'b0, 12'hFF0, 16'h0000);
        exp_q.push_back(m_cyc[15:0]);
        hi_exp = m_cyc[31:16];
        idle(1);
        pop_check("cyc_lo");
        do_read(12'hFF1, hi_exp, "cyc_hi");

        // Done/pass mailbox
        do_write(12'hFF4, 16'h600D);
        idle(1);
        check("done_set", 16'(done), 16'h0001);
        check("pass_set", 16'(pass), 16'h0001);
        do_write(12'hFF4, 16'h0BAD);
        idle(1);
        check("pass_sticky", 16'(pass), 16'h0001);
        check("done_no_err", 16'(error), 16'h0000);
        do_read(12'hFF3, 16'h0003, "status_done");

        // Reset asserted during a read
        drive(1'b1, 1'b1, 1'b0, 12'h010, 16'h0000);
        reset = 1'b0;
        idle(1);
        check("rst_mid_data",  rdata,      16'h0000);
        check("rst_mid_done",  16'(done),  16'h0000);
        check("rst_mid_pass",  16'(pass),  16'h0000);
        check("rst_mid_error", 16'(error), 16'h0000);
        reset = 1'b1;
        do_read(12'hFF1, 16'h0000, "hi_after_rst");
        do_read(12'h010, 16'hBEEF, "ram_survives_rst");

        // Illegal request and read-only write
        drive(1'b1, 1'b1, 1'b1, 12'h030, 16'hFFFF);
        idle(1);
        check("illegal_holds", rdata, 16'hBEEF);
        check("illegal_err", 16'(error), 16'h0001);
        do_write(12'hFF3, 16'h1111);
        idle(1);
        check("ro_err", 16'(error), 16'h0001);
        check("ram_030_kept", dut.u_ram.ram[12'h030], 16'h5555);
        do_read(12'hFF3, 16'h000C, "status_errs");
        do_read(12'h030, 16'h5555, "ram_030_read");
        do_read(12'hFF2, 16'h0000, "scratch_rst");

        // Counter wrap
        @(negedge clock);
        force dut.cyc_q = 32'hFFFF_FFFF;
        #1;
        release dut.cyc_q;
        en = 1'b1; rd = 1'b1; wr = 1'b0; addr = 12'hFF0; wdata = 16'h0000;
        exp_q.push_back(16'hFFFF);
        drive(1'b1, 1'b1, 1'b0, 12'hFF0, 16'h0000);
        pop_check("wrap_lo_pre");
        exp_q.push_back(16'h0000);
        idle(1);
        pop_check("wrap_lo_post");
        do_read(12'hFF1, 16'h0000, "wrap_hi");

        idle(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
